// File: rtl/return_stack.sv
// Return-address stack for subroutine calls and interrupt entry.
// Top of stack is read combinationally; error flags are sticky until clr_err.
module return_stack #(
  parameter int DW    = 10,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          ipush,
  input  logic          pop,
  input  logic          clr_err,
  input  logic [DW-1:0] dato,
  output logic [DW-1:0] data_out,
  output logic          top_is_intr,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Each entry holds {interrupt tag, address}
  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] sp, sp_n, wr_idx;
  logic [AW:0]   cnt_n;
  logic          wr_en, ovf_n, unf_n, pe;
  logic [DW:0]   wval;

  assign pe    = push | ipush;
  assign wval  = {ipush, ipush ? dato : dato + 1'b1};
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign data_out    = empty ? '0 : mem[sp][DW-1:0];
  assign top_is_intr = empty ? 1'b0 : mem[sp][DW];

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sp + 1'b1;
    sp_n   = sp;
    cnt_n  = count;
    ovf_n  = clr_err ? 1'b0 : overflow;
    unf_n  = clr_err ? 1'b0 : underflow;
    if (pe && pop && !empty) begin
      // Replace in place: depth unchanged, so never an overflow
      wr_en  = 1'b1;
      wr_idx = sp;
    end else if (pe) begin
      if (pop) unf_n = 1'b1;
      if (!full) begin
        wr_en = 1'b1;
        sp_n  = sp + 1'b1;
        cnt_n = count + 1'b1;
      end else begin
        ovf_n = 1'b1;
        if (WRAP != 0) begin
          wr_en = 1'b1;
          sp_n  = sp + 1'b1;
        end
      end
    end else if (pop) begin
      if (!empty) begin
        sp_n  = sp - 1'b1;
        cnt_n = count - 1'b1;
      end else begin
        unf_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      count     <= cnt_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wval;
  end

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: one drop-policy and one circular instance
// share the same stimulus, and each is checked against hand-computed values.
module tb_return_stack;
  logic       clk = 1'b0, reset = 1'b1;
  logic       push = 0, ipush = 0, pop = 0, clr_err = 0;
  logic [9:0] dato = '0;

  logic [9:0] d0, d1;
  logic [4:0] c0, c1;
  logic       ti0, ti1, e0, e1, f0, f1, o0, o1, u0, u1;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  return_stack #(.DW(10), .DEPTH(16), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .push(push), .ipush(ipush), .pop(pop),
    .clr_err(clr_err), .dato(dato), .data_out(d0), .top_is_intr(ti0),
    .count(c0), .empty(e0), .full(f0), .overflow(o0), .underflow(u0));

  return_stack #(.DW(10), .DEPTH(16), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .push(push), .ipush(ipush), .pop(pop),
    .clr_err(clr_err), .dato(dato), .data_out(d1), .top_is_intr(ti1),
    .count(c1), .empty(e1), .full(f1), .overflow(o1), .underflow(u1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply current inputs at the next rising edge, then sample 1ns later
  task automatic step(input logic p, input logic ip, input logic po,
                      input logic ce, input logic [9:0] d);
    push = p; ipush = ip; pop = po; clr_err = ce; dato = d;
    @(posedge clk); #1;
    push = 0; ipush = 0; pop = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; #2; reset = 1'b0;
  endtask

  initial begin
    #12 reset = 1'b0;
    @(posedge clk); #1;
    check("rst count", c0, 0);
    check("rst empty", e0, 1);
    check("rst full", f0, 0);
    check("rst data_out", d0, 0);
    check("rst tag", ti0, 0);
    check("rst overflow", o0, 0);
    check("rst underflow", u0, 0);

    // Calls, including the +1 wrap at 0x3FF
    step(1, 0, 0, 0, 10'h005);
    step(1, 0, 0, 0, 10'h010);
    step(1, 0, 0, 0, 10'h3FF);
    check("t1 count", c0, 3);
    check("t1 wrap top", d0, 10'h000);
    check("t1 tag", ti0, 0);
    step(0, 0, 1, 0, 0);
    check("t1 pop1", d0, 10'h011);
    step(0, 0, 1, 0, 0);
    check("t1 pop2", d0, 10'h006);
    check("t1 tag2", ti0, 0);
    step(0, 0, 1, 0, 0);
    check("t1 empty", e0, 1);

    // Interrupt entry is stored unmodified and tagged
    step(0, 1, 0, 0, 10'h120);
    step(1, 0, 0, 0, 10'h050);
    check("t2 top", d0, 10'h051);
    check("t2 tag0", ti0, 0);
    step(0, 0, 1, 0, 0);
    check("t2 intr top", d0, 10'h120);
    check("t2 tag1", ti0, 1);
    step(0, 0, 1, 0, 0);

    // Fill, then push while full
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 10'(i));
    check("t3 full", f0, 1);
    check("t3 no ovf yet", o0, 0);
    step(1, 0, 0, 0, 10'h200);
    check("t3 w0 full", f0, 1);
    check("t3 w0 overflow", o0, 1);
    check("t3 w0 top", d0, 10'h010);
    check("t3 w0 count", c0, 16);
    check("t3 w1 top", d1, 10'h201);
    check("t3 w1 count", c1, 16);
    check("t3 w1 overflow", o1, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    check("t3 w0 last", d0, 10'h001);
    check("t3 w1 last", d1, 10'h002);
    step(0, 0, 1, 0, 0);
    check("t3 w0 empty", e0, 1);
    check("t3 w0 empty data", d0, 0);

    // Circular overwrite of oldest entry
    do_reset();
    check("t4 ovf cleared", o1, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 10'(i));
    check("t4 w1 count", c1, 16);
    check("t4 w1 overflow", o1, 1);
    check("t4 w1 top", d1, 10'h011);
    check("t4 w0 top", d0, 10'h010);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    check("t4 w1 after pops", d1, 10'h002);
    check("t4 w0 after pops", d0, 10'h001);

    // Underflow and clear priority
    do_reset();
    step(0, 0, 1, 0, 0);
    check("t5 underflow", u0, 1);
    check("t5 count", c0, 0);
    check("t5 data", d0, 0);
    step(0, 0, 1, 1, 0);
    check("t5 set beats clr", u0, 1);
    step(0, 0, 0, 1, 0);
    check("t5 clr", u0, 0);

    // Push+pop on empty: behaves as push but flags underflow
    step(1, 0, 1, 0, 10'h010);
    check("t6 pp empty count", c0, 1);
    check("t6 pp empty uf", u0, 1);
    check("t6 pp empty top", d0, 10'h011);
    step(1, 0, 0, 1, 10'h030);
    check("t6 count2", c0, 2);
    check("t6 top", d0, 10'h031);
    check("t6 uf cleared", u0, 0);
    step(1, 0, 1, 0, 10'h040);
    check("t6 replace count", c0, 2);
    check("t6 replace top", d0, 10'h041);
    check("t6 replace no uf", u0, 0);
    step(1, 1, 0, 0, 10'h077);
    check("t6 ipush prio data", d0, 10'h077);
    check("t6 ipush prio tag", ti0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("t6 below replace", d0, 10'h011);

    // Replace at full must not overflow
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 10'(i));
    check("t7 full", f0, 1);
    step(1, 0, 1, 0, 10'h100);
    check("t7 replace full top", d0, 10'h101);
    check("t7 replace full ovf", o0, 0);
    check("t7 replace full count", c0, 16);

    // Asynchronous reset in the middle of a clock phase
    #2 reset = 1'b1;
    #1;
    check("t8 async count", c0, 0);
    check("t8 async empty", e0, 1);
    check("t8 async data", d0, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
